led_pattern_ctrl: RTL and testbench
===================================

# led_pattern_ctrl

Multi-channel LED pattern controller for status indication. Each of `CH` outputs is driven by a per-channel 2-bit mode (off / on / blink / inverted blink) at a programmable blink rate. It also has a per-channel retriggerable one-shot flash that overrides the mode. It sits between the control/state logic (countdown FSM, keys) and the board LED pins, and generalises the single-LED start/pause/stop indicator to N channels.

## Interface
Parameters:
- `CH`, 4: number of LED channels (1–16).
- `TICK_CYCLES`, 50_000: `sclk` cycles per 1 ms tick (50 MHz board clock).
- `HALF_W`, 10: width of `half_ms`.
- `FLASH_MS`, 50: flash duration in ticks (≥1).

Ports:
- `sclk`, in, 1: system clock. One clock domain.
- `nrst`, in, 1: reset, asynchronous, active-low.
- `mode`, in, 2*CH: channel i uses `mode[2i+1:2i]`. 00 = off, 01 = on, 10 = blink, 11 = inverted blink.
- `half_ms`, in, HALF_W: blink half-period in ms, shared by all channels. The value 0 is treated as 1.
- `flash`, in, CH: one-cycle start pulses, one per channel.
- `duty`, in, 4: on-level brightness. Present only with `LED_PWM_DIM_EN`.
- `led`, out, CH: registered LED drive, 1 = lit.

## Operation
- **Tick generator.** `cnt_tick` counts 0..TICK_CYCLES-1 and wraps. `tick` is high for one cycle when `cnt_tick == TICK_CYCLES-1`. The counter is free-running and is not affected by any mode.
- **Blink timer (per channel).**
  - `bcnt[i]` increments on each `tick`.
  - When `bcnt[i]` reaches `max(half_ms,1)-1` on a `tick`, it clears and `phase[i]` toggles.
  - A `half_ms` change takes effect at the next compare. If `bcnt` is already above the new limit, it runs on, wraps at its full width, and then matches.
- **Blink restart.** A mode transition into 10 or 11 from any other mode clears `bcnt[i]` and sets `phase[i]=1`, in the same cycle the new mode is first seen. Switching between 10 and 11 does not restart the timer.
- **Pattern level.**
  - 00 → 0.
  - 01 → ON.
  - 10 → `phase ? ON : 0`.
  - 11 → `phase ? 0 : ON`.
  - ON is 1, or the PWM level when dimming is compiled in.
- **Flash (per channel).**
  - `flash[i]` loads `fcnt[i] = FLASH_MS`.
  - `fcnt[i]` decrements on each `tick` while nonzero.
  - While `fcnt[i] != 0`, `led[i] = 1` at full brightness, overriding any mode.
  - A new `flash[i]` pulse while active reloads the counter (retrigger).
  - If `flash[i]` and `tick` fall in the same cycle, the load wins.
  - Blink timers keep running underneath a flash. When the flash ends, the current pattern level resumes.
- **Priority.** `nrst` > flash > mode.
- **Reset.** All counters = 0, `phase` = 0, `led` = 0. The previous-mode register resets to 00, so a channel held at mode 10 through reset starts blinking with phase 1.

## Timing
- `led` is registered. A mode or flash input sampled at edge k appears on `led` after edge k+1. Latency is 1 cycle.
- **Blink.** The first half-period after entry is `(half_ms-1)·TICK_CYCLES + (cycles to next tick)`. After that, every half-period is exactly `half_ms·TICK_CYCLES` cycles.
- **Flash length.** Between `(FLASH_MS-1)·TICK_CYCLES+1` and `FLASH_MS·TICK_CYCLES` cycles, depending on the tick alignment.
- Asserting `nrst` mid-flash or mid-blink forces `led=0` immediately, without waiting for a clock edge.

## Configuration
- **`LED_PWM_DIM_EN` defined:**
  - Adds the `duty[3:0]` port.
  - A 4-bit counter `pwm_cnt` free-runs on `sclk` (period 16 cycles) and resets to 0.
  - ON = `(pwm_cnt < duty)`, so `duty=0` is dark and `duty=15` is lit 15 of every 16 cycles.
  - Dimming applies to mode 01 and to the lit phase of modes 10/11. Flash remains fully on.
- **Not defined:** there is no `duty` port, ON = 1, and no PWM logic is built.

## Test plan
Run with `CH=4`, `TICK_CYCLES=10`, `FLASH_MS=3`, `half_ms=2`.
- **Reset.** Assert `nrst=0` with all modes 01 → `led=4'b0000` asynchronously. Release reset → `led=4'b1111` after 2 edges.
- **Blink.** `mode[1:0]` 00→10 at edge k → `led[0]=1` at k+1. It toggles to 0 on the 2nd tick after entry, then toggles every 20 cycles. Channel 1 in mode 11 entered in the same cycle is the exact complement.
- **Flash.** Channel 2 in mode 00, `flash[2]` pulse → `led[2]` is 1 for 21–30 cycles, then 0. A retrigger at cycle 15 extends the flash to 3 full ticks after the retrigger.
- **Flash plus blink.** A flash during mode 10 gives constant 1. When the flash ends, `led` equals the `phase` that has been running in the background.
- **`half_ms=0`.** Behaves identically to `half_ms=1`: the LED toggles on every tick.
- **Dimming (`LED_PWM_DIM_EN`).** Mode 01 with `duty=4` → `led` high exactly 4 of every 16 cycles. `duty=0` → `led` constant 0. Flash → `led` constant 1.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern controller: off/on/blink/inverted blink per channel
// plus a retriggerable flash. Define LED_PWM_DIM_EN to add duty-cycle dimming.
module led_pattern_ctrl #(
    parameter int CH          = 4,
    parameter int TICK_CYCLES = 50_000,
    parameter int HALF_W      = 10,
    parameter int FLASH_MS    = 50
) (
    input  logic              sclk,
    input  logic              nrst,
    input  logic [2*CH-1:0]   mode,
    input  logic [HALF_W-1:0] half_ms,
    input  logic [CH-1:0]     flash,
`ifdef LED_PWM_DIM_EN
    input  logic [3:0]        duty,
`endif
    output logic [CH-1:0]     led
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int FW = $clog2(FLASH_MS + 1);

    logic [TW-1:0]     cnt_tick;
    logic              tick;
    logic [HALF_W-1:0] lim;
    logic [2*CH-1:0]   mode_q;
    logic              on_lvl;
    logic [CH-1:0]     led_d;

    assign tick = (cnt_tick == TW'(TICK_CYCLES - 1));
    assign lim  = (half_ms == '0) ? '0 : half_ms - HALF_W'(1);

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            cnt_tick <= '0;
        end else if (tick) begin
            cnt_tick <= '0;
        end else begin
            cnt_tick <= cnt_tick + TW'(1);
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    assign on_lvl = (pwm_cnt < duty);
`else
    assign on_lvl = 1'b1;
`endif

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            mode_q <= '0;
            led    <= '0;
        end else begin
            mode_q <= mode;
            led    <= led_d;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [HALF_W-1:0] bcnt;
        logic              phase;
        logic [FW-1:0]     fcnt;
        logic [1:0]        m_cur;
        logic              restart;
        logic              lvl;

        assign m_cur = mode_q[2*i +: 2];
        // entering blink from off/on restarts; 10<->11 keeps the timer
        assign restart = mode[2*i+1] & ~mode_q[2*i+1];

        always_ff @(posedge sclk or negedge nrst) begin
            if (!nrst) begin
                bcnt  <= '0;
                phase <= 1'b0;
            end else if (restart) begin
                bcnt  <= '0;
                phase <= 1'b1;
            end else if (tick) begin
                if (bcnt == lim) begin
                    bcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    bcnt <= bcnt + HALF_W'(1);
                end
            end
        end

        always_ff @(posedge sclk or negedge nrst) begin
            if (!nrst) begin
                fcnt <= '0;
            end else if (flash[i]) begin
                fcnt <= FW'(FLASH_MS);
            end else if (tick && fcnt != '0) begin
                fcnt <= fcnt - FW'(1);
            end
        end

        always_comb begin
            lvl = 1'b0;
            unique case (m_cur)
                2'b01:   lvl = on_lvl;
                2'b10:   lvl = phase ? on_lvl : 1'b0;
                2'b11:   lvl = phase ? 1'b0 : on_lvl;
                default: lvl = 1'b0;
            endcase
        end

        assign led_d[i] = (fcnt != '0) | lvl;
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl (CH=4, TICK_CYCLES=10, FLASH_MS=3).
// Edge n = nth rising edge after reset release; ticks land on edges 10, 20, ...
module tb_led_pattern_ctrl;

    logic       sclk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] mode = '0;
    logic [9:0] half_ms = 10'd2;
    logic [3:0] flash = '0;
`ifdef LED_PWM_DIM_EN
    logic [3:0] duty = 4'd15;
`endif
    logic [3:0] led;

    int n_chk = 0;
    int n_fail = 0;
    int ecnt;

    led_pattern_ctrl #(
        .CH(4),
        .TICK_CYCLES(10),
        .HALF_W(10),
        .FLASH_MS(3)
    ) dut (
        .sclk(sclk),
        .nrst(nrst),
        .mode(mode),
        .half_ms(half_ms),
        .flash(flash),
`ifdef LED_PWM_DIM_EN
        .duty(duty),
`endif
        .led(led)
    );

    always #5 sclk = ~sclk;

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) ecnt <= 0;
        else ecnt <= ecnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic [7:0] m, input logic [9:0] h);
        @(negedge sclk);
        nrst = 1'b0;
        mode = m;
        half_ms = h;
        flash = '0;
        @(negedge sclk);
        nrst = 1'b1;
    endtask

    task automatic tick_to(input int n);
        while (ecnt < n) @(negedge sclk);
    endtask

    task automatic test_reset;
        do_reset(8'b0101_0101, 10'd2);
        n_chk++;
        if (led !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: led=%b expected 0000", led);
        end
        tick_to(1);
        n_chk++;
        if (led !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_edge1: led=%b expected 0000", led);
        end
        tick_to(2);
        n_chk++;
        if (led !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_edge2: led=%b expected 1111", led);
        end
        tick_to(5);
        #2 nrst = 1'b0;
        #1;
        n_chk++;
        if (led !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: led=%b expected 0000", led);
        end
        @(negedge sclk);
        nrst = 1'b1;
    endtask

    task automatic test_blink;
        int         ev [6];
        logic [3:0] xv [6];
        int         fv [3];
        logic [3:0] yv [3];
        ev = '{4, 5, 20, 21, 40, 41};
        xv = '{4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0001};
        fv = '{53, 60, 61};
        yv = '{4'b0000, 4'b0000, 4'b0011};
        do_reset(8'h00, 10'd2);
        tick_to(3);
        mode = 8'b0000_1110;
        foreach (ev[k]) begin
            tick_to(ev[k]);
            n_chk++;
            if (led !== xv[k]) begin
                n_fail++;
                $display("FAIL blink@%0d: led=%b expected %b", ev[k], led, xv[k]);
            end
        end
        // 10 -> 11 mid half-period must not restart the timer
        tick_to(51);
        mode = 8'b0000_1111;
        foreach (fv[k]) begin
            tick_to(fv[k]);
            n_chk++;
            if (led !== yv[k]) begin
                n_fail++;
                $display("FAIL blink_swap@%0d: led=%b expected %b", fv[k], led, yv[k]);
            end
        end
    endtask

    task automatic test_half_zero;
        int         ev [5];
        logic [3:0] xv [5];
        ev = '{10, 11, 20, 21, 31};
        xv = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        for (int h = 0; h < 2; h++) begin
            do_reset(8'h00, 10'(h));
            tick_to(3);
            mode = 8'b0000_0010;
            foreach (ev[k]) begin
                tick_to(ev[k]);
                n_chk++;
                if (led !== xv[k]) begin
                    n_fail++;
                    $display("FAIL half%0d@%0d: led=%b expected %b", h, ev[k], led, xv[k]);
                end
            end
        end
    endtask

    task automatic test_flash;
        int         ev [4];
        logic [3:0] xv [4];
        ev = '{3, 4, 30, 31};
        xv = '{4'b0000, 4'b0100, 4'b0100, 4'b0000};
        do_reset(8'h00, 10'd2);
        tick_to(2);
        flash = 4'b0100;
        tick_to(3);
        flash = 4'b0000;
        foreach (ev[k]) begin
            tick_to(ev[k]);
            n_chk++;
            if (led !== xv[k]) begin
                n_fail++;
                $display("FAIL flash@%0d: led=%b expected %b", ev[k], led, xv[k]);
            end
        end
    endtask

    task automatic test_retrigger;
        int         ev [3];
        logic [3:0] xv [3];
        ev = '{31, 40, 41};
        xv = '{4'b0100, 4'b0100, 4'b0000};
        do_reset(8'h00, 10'd2);
        tick_to(2);
        flash = 4'b0100;
        tick_to(3);
        flash = 4'b0000;
        tick_to(14);
        flash = 4'b0100;
        tick_to(15);
        flash = 4'b0000;
        foreach (ev[k]) begin
            tick_to(ev[k]);
            n_chk++;
            if (led !== xv[k]) begin
                n_fail++;
                $display("FAIL retrig@%0d: led=%b expected %b", ev[k], led, xv[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int         ev [3];
        logic [3:0] xv [3];
        ev = '{11, 40, 41};
        xv = '{4'b1001, 4'b1001, 4'b0000};
        do_reset(8'h00, 10'd2);
        // pulse lands in the tick cycle: load must win
        tick_to(9);
        flash = 4'b1001;
        tick_to(10);
        flash = 4'b0000;
        foreach (ev[k]) begin
            tick_to(ev[k]);
            n_chk++;
            if (led !== xv[k]) begin
                n_fail++;
                $display("FAIL flash_tick@%0d: led=%b expected %b", ev[k], led, xv[k]);
            end
        end
    endtask

    task automatic test_flash_blink;
        int         ev [5];
        logic [3:0] xv [5];
        ev = '{41, 61, 70, 71, 81};
        xv = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
        do_reset(8'h00, 10'd2);
        tick_to(3);
        mode = 8'b0000_0010;
        tick_to(44);
        flash = 4'b0001;
        tick_to(45);
        flash = 4'b0000;
        foreach (ev[k]) begin
            tick_to(ev[k]);
            n_chk++;
            if (led !== xv[k]) begin
                n_fail++;
                $display("FAIL flash_blink@%0d: led=%b expected %b", ev[k], led, xv[k]);
            end
        end
    endtask

`ifdef LED_PWM_DIM_EN
    task automatic test_pwm;
        int lit;
        duty = 4'd4;
        do_reset(8'b0000_0001, 10'd2);
        lit = 0;
        for (int k = 17; k < 33; k++) begin
            tick_to(k);
            lit += int'(led[0]);
        end
        n_chk++;
        if (lit !== 4) begin
            n_fail++;
            $display("FAIL pwm_duty4: lit=%0d expected 4", lit);
        end
        tick_to(40);
        duty = 4'd0;
        lit = 0;
        for (int k = 41; k < 57; k++) begin
            tick_to(k);
            lit += int'(led[0]);
        end
        n_chk++;
        if (lit !== 0) begin
            n_fail++;
            $display("FAIL pwm_duty0: lit=%0d expected 0", lit);
        end
        tick_to(60);
        flash = 4'b0001;
        tick_to(61);
        flash = 4'b0000;
        lit = 0;
        for (int k = 62; k < 78; k++) begin
            tick_to(k);
            lit += int'(led[0]);
        end
        n_chk++;
        if (lit !== 16) begin
            n_fail++;
            $display("FAIL pwm_flash: lit=%0d expected 16", lit);
        end
        duty = 4'd15;
    endtask
`endif

    initial begin
        test_reset();
        test_blink();
        test_half_zero();
        test_flash();
        test_retrigger();
        test_back_to_back();
        test_flash_blink();
`ifdef LED_PWM_DIM_EN
        test_pwm();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
